// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, Q-format limits and saturation helper
// for the FIR tap accumulator.
package fir_pkg;

    localparam logic signed [15:0] Q15_MAX = 16'sh7fff;
    localparam logic signed [15:0] Q15_MIN = 16'sh8000;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] val;
    } sat_t;

    function automatic int acc_width(input int multbits, input int taps);
        return multbits + $clog2(taps) + 1;
    endfunction

    // Values wider than 64 bits are not supported by the clamp.
    function automatic sat_t sat_clamp(input logic signed [63:0] value,
                                       input int outbits);
        sat_t r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (outbits - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        r.sat = 1'b1;
        if (value > hi) begin
            r.val = hi;
        end else if (value < lo) begin
            r.val = lo;
        end else begin
            r.val = value;
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// fir_round_sat: shift, optional round, saturate and register the tree sum.
// Build option FIR_ACC_ROUND_EN selects round-half-up over truncation.
module fir_round_sat #(
    parameter int ACCBITS    = 42,
    parameter int FRAC_SHIFT = 15,
    parameter int OUTBITS    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic signed [ACCBITS-1:0] sum_i,
    input  logic                      in_valid_i,
    output logic signed [OUTBITS-1:0] out_o,
    output logic                      out_valid_o,
    output logic                      sat_event_o
);
    import fir_pkg::*;

    logic signed [ACCBITS-1:0] shifted;
    sat_t                      clamp;
    logic signed [OUTBITS-1:0] out_d;
    logic signed [OUTBITS-1:0] out_q;
    logic                      valid_q;
    logic                      sat_q;

`ifdef FIR_ACC_ROUND_EN
    localparam logic signed [ACCBITS-1:0] HALF =
        ACCBITS'(1) <<< (FRAC_SHIFT - 1);
    // The guard bit in ACCBITS keeps this add from overflowing.
    assign shifted = (sum_i + HALF) >>> FRAC_SHIFT;
`else
    assign shifted = sum_i >>> FRAC_SHIFT;
`endif

    assign clamp = sat_clamp(64'(shifted), OUTBITS);
    assign out_d = OUTBITS'(clamp.val);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            valid_q <= in_valid_i;
            sat_q   <= in_valid_i & clamp.sat;
            if (in_valid_i) begin
                out_q <= out_d;
            end
        end
    end

    assign out_o       = out_q;
    assign out_valid_o = valid_q;
    assign sat_event_o = sat_q;

endmodule

// File: rtl/fir_tree_accumulator.sv
// fir_tree_accumulator: pipelined signed adder tree feeding fir_round_sat.
// Build option FIR_ACC_ROUND_EN enables round-half-up in the output stage.
module fir_tree_accumulator #(
    parameter int TAPS       = 401,
    parameter int MULTBITS   = 32,
    parameter int FRAC_SHIFT = 15,
    parameter int OUTBITS    = 16,
    parameter int REG_STRIDE = 1,
    parameter int CNTBITS    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid_i,
    input  logic signed [MULTBITS-1:0] multiplier_out_i [0:TAPS-1],
    input  logic                       sat_clear_i,
    output logic signed [OUTBITS-1:0]  out_o,
    output logic                       out_valid_o,
    output logic                       sat_event_o,
    output logic                       sat_sticky_o,
    output logic [CNTBITS-1:0]         sample_count_o
);
    import fir_pkg::*;

    localparam int LOGP    = $clog2(TAPS);
    localparam int NLEAF   = 1 << LOGP;
    localparam int ACCBITS = acc_width(MULTBITS, TAPS);
    localparam int NREG    = (LOGP + REG_STRIDE - 1) / REG_STRIDE;

    // Heap layout: node n sums children 2n and 2n+1; leaves start at NLEAF.
    logic signed [ACCBITS-1:0] nd [1:2*NLEAF-1];
    logic [NREG-1:0]           vld_q;
    logic [NREG:0]             v;
    logic [CNTBITS-1:0]        cnt_q;
    logic [CNTBITS-1:0]        cnt_d;
    logic                      sticky_q;
    logic                      sticky_d;

    assign v = {vld_q, in_valid_i};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= v[NREG-1:0];
        end
    end

    for (genvar i = 0; i < NLEAF; i++) begin : g_leaf
        if (i < TAPS) begin : g_tap
            assign nd[NLEAF+i] = ACCBITS'(multiplier_out_i[i]);
        end else begin : g_pad
            assign nd[NLEAF+i] = '0;
        end
    end

    for (genvar n = 1; n < NLEAF; n++) begin : g_node
        localparam int K = LOGP + 1 - $clog2(n + 1);
        logic signed [ACCBITS-1:0] sum_d;
        assign sum_d = nd[2*n] + nd[2*n+1];
        if ((K % REG_STRIDE == 0) || (K == LOGP)) begin : g_reg
            localparam int J = (K + REG_STRIDE - 1) / REG_STRIDE;
            logic signed [ACCBITS-1:0] sum_q;
            always_ff @(posedge clk) begin
                if (v[J-1]) begin
                    sum_q <= sum_d;
                end
            end
            assign nd[n] = sum_q;
        end else begin : g_comb
            assign nd[n] = sum_d;
        end
    end

    fir_round_sat #(
        .ACCBITS    (ACCBITS),
        .FRAC_SHIFT (FRAC_SHIFT),
        .OUTBITS    (OUTBITS)
    ) u_round_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .sum_i       (nd[1]),
        .in_valid_i  (v[NREG]),
        .out_o       (out_o),
        .out_valid_o (out_valid_o),
        .sat_event_o (sat_event_o)
    );

    assign cnt_d    = out_valid_o ? cnt_q + CNTBITS'(1) : cnt_q;
    assign sticky_d = sat_event_o | (sticky_q & ~sat_clear_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign sample_count_o = cnt_q;
    assign sat_sticky_o   = sticky_q;

endmodule

// File: doc/fir_tree_accumulator.md
Name: fir_tree_accumulator

Overview:
Next-generation FIR tap accumulator. Sums TAPS signed products through a pipelined binary adder tree, with a configurable register stride. A final stage shifts the sum, optionally rounds it, and saturates it to the OUTBITS Q-format output. Adds synchronous reset, a saturation event and sticky flag, and an output sample counter. Sits between the per-tap multiplier array and the FIR output stream.

Parameters:
TAPS, 401, number of products summed; must be >= 2.
MULTBITS, 32, product width, signed.
FRAC_SHIFT, 15, arithmetic right shift applied to the sum; must be >= 1.
OUTBITS, 16, output width; output is Q1.(OUTBITS-1).
REG_STRIDE, 1, pipeline register after every REG_STRIDE tree levels; must be >= 1.
CNTBITS, 32, sample counter width.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous active-low reset.
in_valid  in  1  multiplier_out holds a valid product set this cycle.
multiplier_out  in  TAPS x MULTBITS  signed products, unpacked array [0:TAPS-1].
sat_clear  in  1  clears sat_sticky.
out  out  OUTBITS  signed filtered sample.
out_valid  out  1  out is valid this cycle; 1-cycle pulse per sample.
sat_event  out  1  high together with out_valid when that sample was clamped.
sat_sticky  out  1  set by any sat_event, held until sat_clear.
sample_count  out  CNTBITS  number of out_valid pulses since reset.

Behaviour:
- Reset is synchronous and active-low: it applies on a clk rising edge while rst_n=0. During reset, out=0, out_valid=0, sat_event=0, sat_sticky=0, sample_count=0, and all valid pipeline bits clear. Tree data registers need no reset.
- Widths: LOGP=$clog2(TAPS); ACCBITS=MULTBITS+LOGP+1 (one guard bit for rounding). Inputs are sign-extended to ACCBITS. Tree leaves at index >= TAPS are zero.
- Tree: LOGP adder levels. Registers sit after level k when k mod REG_STRIDE==0 or k==LOGP. NREG=ceil(LOGP/REG_STRIDE).
- Output stage: one register holding out, out_valid, and sat_event.
- Latency: L=NREG+1 cycles from the in_valid edge to out_valid. Throughput is 1 sample/cycle. There is no backpressure.
- Valid pipeline: each register stage captures data only when its incoming valid bit is 1; otherwise it holds. Valid bits always shift. Gaps in in_valid are reproduced exactly on out_valid.
- Round/shift: with the feature enabled, r=(sum+2^(FRAC_SHIFT-1))>>>FRAC_SHIFT; otherwise r=sum>>>FRAC_SHIFT. Both are arithmetic shifts.
- Saturation: r is clamped to [-2^(OUTBITS-1), 2^(OUTBITS-1)-1]. sat_event=1 when clamping occurred.
- out holds its last value while out_valid=0.
- sample_count increments on each out_valid and wraps modulo 2^CNTBITS.
- sat_sticky: sat_event sets it and sat_clear clears it. If both happen in the same cycle, set wins. The new value is visible the next cycle.
- Reset mid-operation drops all in-flight samples. No out_valid is produced for them after reset releases.
- in_valid asserted while rst_n=0 is ignored.

Optional Feature:
Macro FIR_ACC_ROUND_EN.
- Defined: round-half-up, adding 2^(FRAC_SHIFT-1) before the shift.
- Undefined: truncation toward negative infinity. No adder is generated.
- Latency and all other behaviour are identical in both builds.

Decomposition:
- Package fir_pkg holds:
  - Q-format constants (Q15 max/min).
  - Function acc_width(multbits, taps).
  - Function sat_clamp(value, outbits) returning the clamped value plus a flag.
- Sub-module fir_round_sat holds the shift/round/saturate output register stage, with ports sum, in_valid, out, out_valid, sat_event.
- Tree, valid pipeline, sticky flag, and counter stay in the top module.

Test Plan:
1. Impulse. Config TAPS=4, REG_STRIDE=1, so L=3. Drive multiplier_out={32768,0,0,0} with in_valid for 1 cycle -> out=1 with out_valid exactly 3 cycles later, sample_count=1, sat_event=0.
2. Rounding. Drive {16384,16384,16384,0} (sum 49152) -> out=2 with FIR_ACC_ROUND_EN, 1 without. Drive the negated inputs -> out=-1 with the macro, -2 without.
3. Saturation. Drive all four taps=655360000 -> out=32767, sat_event=1, sat_sticky=1. All taps=-655360000 -> out=-32768. Then sat_clear together with a new saturating sample -> sat_sticky stays 1. sat_clear alone -> sat_sticky=0 next cycle.
4. Streaming. Drive in_valid 8 consecutive cycles with ramp taps {k*32768,0,0,0}, k=1..8, then the pattern 1,0,1,1,0 -> outputs 1..8 in order on consecutive cycles, then the identical gap pattern, sample_count=11.
5. Reset mid-flight. Pull rst_n low for 1 cycle with 2 samples in flight -> no further out_valid; out=0, sample_count=0, sat_sticky=0.
6. Deep config. TAPS=401, REG_STRIDE=3, all taps=32768 -> latency 4 cycles, out=401. Repeat with REG_STRIDE=1 -> latency 10.
